// File: rtl/display_tx_fifo_pkg.sv
// Shared definitions for the display character buffer: output FSM encoding,
// display register address and default sizing.
package display_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2,
        ST_PACE   = 2'd3
    } state_t;

    localparam logic TX_ADDR            = 1'b0;
    localparam int   DEFAULT_DEPTH      = 16;
    localparam int   DEFAULT_ADDR_W     = 4;
    localparam int   DEFAULT_PACE_W     = 17;
    localparam int   DEFAULT_PACE_TICKS = 0;

endpackage

// File: rtl/display_tx_fifo_if.sv
// CPU-side and display-side signals of the character buffer. The buffer
// itself uses the slave modport; whoever drives the CPU side uses master.
interface display_tx_fifo_if;
    logic       pixel_clken;
    logic       cpu_clken;
    logic       cpu_wr;
    logic [7:0] cpu_din;
    logic       clr_screen;
    logic       dsp_busy;
    logic       overflow;
    logic       out_clken;
    logic       out_w_en;
    logic       out_address;
    logic [7:0] out_dout;

    modport master (
        output pixel_clken, cpu_clken, cpu_wr, cpu_din, clr_screen,
        input  dsp_busy, overflow, out_clken, out_w_en, out_address, out_dout
    );

    modport slave (
        input  pixel_clken, cpu_clken, cpu_wr, cpu_din, clr_screen,
        output dsp_busy, overflow, out_clken, out_w_en, out_address, out_dout
    );
endinterface

// File: rtl/display_tx_fifo_sync_fifo.sv
// Single-clock FIFO with asynchronous head read and a flush that wins over
// push/pop. Pointers wrap naturally; count is one bit wider than them.
module sync_fifo
    import display_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
        end
    end
endmodule

// File: rtl/display_tx_fifo.sv
// Buffers CPU display writes and replays them as one-tick write strobes,
// each followed by a gap and optional pacing delay, on pixel_clken ticks.
//
// state  | meaning
// IDLE   | waiting for a buffered character; pops and raises the strobe
// STROBE | strobe high for this tick; drops it next
// GAP    | mandatory low tick before the display takes another character
// PACE   | optional extra wait emulating the terminal character rate
module display_tx_fifo
    import display_tx_fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int PACE_W     = DEFAULT_PACE_W,
    parameter int PACE_TICKS = DEFAULT_PACE_TICKS
) (
    input  logic             pixel_clock,
    input  logic             reset_n,
    display_tx_fifo_if.slave bus
);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [PACE_W-1:0] PACE_LOAD  =
        PACE_W'((PACE_TICKS > 0) ? PACE_TICKS - 1 : 0);

    state_t            state;
    logic [PACE_W-1:0] pace_cnt;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [7:0]        head;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;

    assign push_req   = bus.cpu_clken & bus.cpu_wr;
    assign push       = push_req & ~full & ~bus.clr_screen;
    assign pop        = bus.pixel_clken & (state == ST_IDLE) & ~empty & ~bus.clr_screen;
    assign count_next = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    assign bus.out_address = TX_ADDR;

    sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(8)) u_fifo (
        .clk   (pixel_clock),
        .rst_n (reset_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.clr_screen),
        .din   (bus.cpu_din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // busy tracks the occupancy after this edge's push and pop
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.overflow <= 1'b0;
            bus.dsp_busy <= 1'b0;
        end else if (bus.clr_screen) begin
            bus.overflow <= 1'b0;
            bus.dsp_busy <= 1'b0;
        end else begin
            if (push_req && full) bus.overflow <= 1'b1;
            bus.dsp_busy <= (count_next == FULL_COUNT);
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            pace_cnt      <= '0;
            bus.out_w_en  <= 1'b0;
            bus.out_clken <= 1'b0;
            bus.out_dout  <= 8'h00;
        end else if (bus.clr_screen && state != ST_STROBE) begin
            // a strobe already on the wire is allowed to finish
            state    <= ST_IDLE;
            pace_cnt <= '0;
        end else if (bus.pixel_clken) begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        bus.out_dout  <= head;
                        bus.out_w_en  <= 1'b1;
                        bus.out_clken <= 1'b1;
                        state         <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    bus.out_w_en  <= 1'b0;
                    bus.out_clken <= 1'b0;
                    state         <= ST_GAP;
                end
                ST_GAP: begin
                    if (PACE_TICKS != 0) begin
                        pace_cnt <= PACE_LOAD;
                        state    <= ST_PACE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PACE: begin
                    if (pace_cnt == '0) state <= ST_IDLE;
                    else                pace_cnt <= pace_cnt - PACE_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/display_tx_fifo.md
Name: display_tx_fifo

Overview:
- Character buffer between the CPU's display data register (PIA port B) and the text display stage.
- Accepts CPU writes at CPU rate and stores them in a small FIFO.
- Replays them to the display as one-character write strobes. Each strobe is followed by a deassert gap, which the display needs before it accepts the next character.
- Provides the display-ready status bit (bit 7) for CPU reads. Optionally paces output to emulate the original terminal's character rate.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..64
ADDR_W, 4, log2(DEPTH)
PACE_W, 17, width of pace counter
PACE_TICKS, 0, extra pixel_clken ticks to wait after each character (0 = no pacing; 116666 ≈ 60 chars/s at 7 MHz)

Ports:
pixel_clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pixel_clken  in  1  pixel clock enable; paces the output side
cpu_clken  in  1  CPU clock enable strobe
cpu_wr  in  1  CPU write to display data register, qualified by cpu_clken
cpu_din  in  8  CPU write data
clr_screen  in  1  clear-screen request; flushes FIFO
dsp_busy  out  1  CPU-visible bit 7; 1 = cannot accept a character
overflow  out  1  sticky; a write was dropped while full
out_clken  out  1  to display cpu_clken
out_w_en  out  1  to display w_en
out_address  out  1  to display address; constant 0 (TX register)
out_dout  out  8  to display din

Behaviour:
- Reset (reset_n low, async): FIFO empty, rd/wr pointers 0, count 0, state IDLE, pace_cnt 0. Outputs: dsp_busy 0, overflow 0, out_clken 0, out_w_en 0, out_dout 8'h00, out_address 0.
- Push:
  - On a clock edge with cpu_clken & cpu_wr and count < DEPTH, store cpu_din at wr_ptr; wr_ptr+1 mod DEPTH; count+1.
  - At most one push per cpu_clken-qualified cycle. Push is independent of pixel_clken.
- Full: a push attempt with count == DEPTH is dropped and sets overflow. Overflow clears only on reset or clr_screen.
- dsp_busy is registered: 1 when count == DEPTH, else 0. It reflects the count after the current edge's push and pop.
- Output state machine (advances only on edges with pixel_clken):
  - IDLE: if count > 0, out_dout <= mem[rd_ptr]; rd_ptr+1; count-1; out_w_en <= 1; out_clken <= 1; go to STROBE.
  - STROBE: out_w_en <= 0; out_clken <= 0; go to GAP. The strobe is high for exactly one pixel_clken period.
  - GAP: hold both low for one pixel_clken period. Then go to PACE if PACE_TICKS != 0 (load pace_cnt <= PACE_TICKS-1), else IDLE.
  - PACE: decrement pace_cnt; when pace_cnt == 0, go to IDLE.
- Minimum character period is 3 pixel_clken ticks: IDLE, STROBE, GAP. With pacing it is 3 + PACE_TICKS.
- Latency: a push at edge N to an empty FIFO in IDLE raises out_w_en at the first pixel_clken edge strictly after N.
- Simultaneous push and pop in one edge: count unchanged, both pointers advance. Writing into the location being read is impossible (pop reads the old head).
- Pointer wrap: pointers are ADDR_W bits, wrap naturally. count is ADDR_W+1 bits.
- clr_screen (sampled every edge, priority over push and pop):
  - FIFO flushed (pointers and count 0); overflow cleared; dsp_busy 0.
  - If state is STROBE, the strobe completes normally. Otherwise state goes to IDLE and pace_cnt goes to 0.
  - A push in the same cycle as clr_screen is discarded.
- Data is passed unmodified. Character mapping and control-code handling belong to the display stage.
- Memory: register array or inferred RAM with asynchronous read of mem[rd_ptr]. out_dout is registered, held stable from the STROBE until the next pop.

Decomposition:
- Shared package (display_pkg): state encoding (IDLE, STROBE, GAP, PACE as 2-bit constants), TX register address constant 1'b0, default DEPTH/PACE constants.
- One natural sub-module: sync_fifo (parameterised DEPTH/ADDR_W/width 8; push, pop, flush, full, empty, count). The top holds the output FSM, the pace counter and the overflow/busy logic.

Test Plan:
- Reset then single write: cpu_wr with cpu_din=8'hC1, pixel_clken every cycle -> out_w_en and out_clken high for exactly 1 cycle with out_dout=8'hC1; low for ≥2 following cycles; dsp_busy stays 0.
- Burst of 16 writes on back-to-back cpu_clken, output held off (pixel_clken=0): dsp_busy=1 after the 16th. 17th write (8'hFF) dropped -> overflow=1. Then enable pixel_clken -> 16 strobes in write order, spaced 3 ticks apart, no 8'hFF; dsp_busy drops after the first pop.
- Simultaneous push/pop at count=1: count remains 1, data order preserved across pointer wrap. Run 40 characters through a DEPTH=16 FIFO; output sequence must equal input.
- PACE_TICKS=5: two queued chars -> strobes exactly 8 pixel_clken ticks apart.
- clr_screen asserted with 5 queued chars during GAP: no further strobes, count=0, overflow=0. A write in the same cycle is not emitted.
- reset_n low mid-STROBE, asynchronously: out_w_en and out_clken fall immediately without waiting for a clock; FIFO empty after release.
